imem_loader: RTL and testbench

Streams a program image into the core's instruction memory through its write port (`write_en`/`write_addr`/`write_data`) and holds the core in reset until the load completes. It accepts bytes on a valid/ready byte interface, for example from a UART receiver or a debug bridge, and packs them little-endian into 32-bit words. Each word is written to sequential word addresses starting at 0. It replaces bench-driven preloading of the instruction memory.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// master = the loader; slave = byte source / instruction memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       write_data;

    modport master (
        input  s_valid, s_data,
        output s_ready, write_en, write_addr, write_data
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, write_en, write_addr, write_data
    );
endinterface

// File: rtl/imem_loader.sv
// Streams little-endian bytes into instruction memory and holds the core in reset until done.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    imem_loader_if.master     bus,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   len_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_r;
    logic [ADDR_W:0]   next_idx_s;
    logic [31:0]       full_word_s;
    logic              accept_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_r;
`endif

    // Places byte k of the first three bytes of a word; the fourth byte is taken straight from the bus.
    function automatic logic [23:0] pack_byte(input logic [23:0] w, input logic [1:0] k,
                                              input logic [7:0] b);
        logic [23:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r        = w;
        endcase
        return r;
    endfunction

    assign next_idx_s  = idx_r + IDX_ONE;
    assign full_word_s = {bus.s_data, word_r};
    assign accept_s    = bus.s_valid & bus.s_ready;

    // Load sequencer with registered handshake, write-port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            len_r          <= '0;
            byte_cnt_r     <= 2'd0;
            word_r         <= 24'd0;
            bus.s_ready    <= 1'b0;
            bus.write_en   <= 1'b0;
            bus.write_addr <= '0;
            bus.write_data <= 32'd0;
            core_rst       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r         <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    bus.s_ready  <= 1'b0;
                    bus.write_en <= 1'b0;
                    if (start) begin
                        if ((len_words == '0) || (len_words > CAPACITY)) begin
                            err      <= 1'b1;
                            done     <= 1'b0;
                            core_rst <= 1'b1;
                        end else begin
                            done        <= 1'b0;
                            err         <= 1'b0;
                            core_rst    <= 1'b1;
                            busy        <= 1'b1;
                            bus.s_ready <= 1'b1;
                            idx_r       <= '0;
                            len_r       <= len_words;
                            byte_cnt_r  <= 2'd0;
                            state_r     <= RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_r      <= 32'd0;
`endif
                        end
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        word_r     <= pack_byte(word_r, byte_cnt_r, bus.s_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            bus.s_ready    <= 1'b0;
                            bus.write_en   <= 1'b1;
                            bus.write_addr <= idx_r[ADDR_W-1:0];
                            bus.write_data <= full_word_s;
                            state_r        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    bus.write_en <= 1'b0;
                    idx_r        <= next_idx_s;
                    byte_cnt_r   <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_r       <= csum_r + bus.write_data;
`endif
                    if (next_idx_s == len_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        bus.s_ready <= 1'b1;
                        state_r     <= CSUM;
`else
                        done        <= 1'b1;
                        core_rst    <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= DONE;
`endif
                    end else begin
                        bus.s_ready <= 1'b1;
                        state_r     <= RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Trailer bytes reuse the word packer; the comparison happens on the fourth byte.
                CSUM: begin
                    if (accept_s) begin
                        word_r     <= pack_byte(word_r, byte_cnt_r, bus.s_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            bus.s_ready <= 1'b0;
                            busy        <= 1'b0;
                            if (full_word_s == csum_r) begin
                                done     <= 1'b1;
                                core_rst <= 1'b0;
                                state_r  <= DONE;
                            end else begin
                                err      <= 1'b1;
                                core_rst <= 1'b1;
                                state_r  <= IDLE;
                            end
                        end
                    end
                end
`endif
                DONE: begin
                    bus.s_ready  <= 1'b0;
                    bus.write_en <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    bus.s_ready  <= 1'b0;
                    bus.write_en <= 1'b0;
                    busy         <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level model predicts every write and the done/err outcome.
// Checksum scenarios run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len_words = '0;
    logic              core_rst, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .bus       (bus),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: bytes seen accepted, words expected, outcome expected
    bit          m_active = 1'b0, m_pending = 1'b0, m_exp_done = 1'b0;
    bit          m_trailer = 1'b0, m_exp_res = 1'b0;
    int          m_len = 0, m_wr = 0, m_nb = 0;
    logic [31:0] m_word = 32'd0, m_sum = 32'd0, m_trl = 32'd0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    logic [7:0]        tx_q[$];
    logic [31:0]       tx_sum = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hA5C30F11;
    endfunction

    // compare process: observes accepted bytes, predicts writes and the final outcome
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_active = 1'b0; m_pending = 1'b0; m_exp_done = 1'b0;
                m_exp_res = 1'b0; m_trailer = 1'b0;
            end else begin
                if (bus.write_en) begin
                    log_addr.push_back(bus.write_addr);
                    log_data.push_back(bus.write_data);
                end
                if (m_exp_done) begin
                    check("done_rise", done, 1);
                    check("core_rst_fall", core_rst, 0);
                    check("busy_clear", busy, 0);
                    m_exp_done = 1'b0; m_active = 1'b0;
                end
                if (m_exp_res) begin
                    if (m_trl == m_sum) begin
                        check("csum_done", done, 1);
                        check("csum_core_rst", core_rst, 0);
                    end else begin
                        check("csum_err", err, 1);
                        check("csum_core_rst_held", core_rst, 1);
                    end
                    check("csum_busy", busy, 0);
                    m_exp_res = 1'b0; m_active = 1'b0;
                end
                if (m_pending) begin
                    check("write_en", bus.write_en, 1);
                    check("write_addr", bus.write_addr, m_wr[ADDR_W-1:0]);
                    check("write_data", bus.write_data, m_word);
                    check("s_ready_in_write", bus.s_ready, 0);
                    m_sum = m_sum + m_word;
                    m_wr++;
                    m_pending = 1'b0;
                    if (m_wr == m_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        m_trailer = 1'b1;
`else
                        m_exp_done = 1'b1;
`endif
                    end
                end else begin
                    check("no_write", bus.write_en, 0);
                end
                if (m_active && bus.s_valid && bus.s_ready) begin
                    if (m_trailer) m_trl[8*m_nb +: 8] = bus.s_data;
                    else           m_word[8*m_nb +: 8] = bus.s_data;
                    m_nb++;
                    if (m_nb == 4) begin
                        m_nb = 0;
                        if (m_trailer) begin
                            m_trailer = 1'b0; m_exp_res = 1'b1;
                        end else begin
                            m_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic push_raw(input logic [31:0] w);
        for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        push_raw(w);
        tx_sum = tx_sum + w;
    endtask

    task automatic push_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_raw(tx_sum);
`endif
        tx_sum = 32'd0;
    endtask

    task automatic start_load(input int n);
        @(posedge clk); #1;
        start = 1'b1; len_words = n[ADDR_W:0];
        m_len = n; m_wr = 0; m_nb = 0; m_sum = 32'd0; m_trailer = 1'b0; m_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("s_ready_rise", bus.s_ready, 1);
    endtask

    task automatic bad_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; len_words = n[ADDR_W:0];
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_len_err", err, 1);
        check("bad_len_core_rst", core_rst, 1);
        check("bad_len_busy", busy, 0);
        check("bad_len_s_ready", bus.s_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_len_no_write", log_addr.size(), 0);
    endtask

    // drives the queued bytes; toggle gates s_valid every other cycle, ign_at pulses a stray start
    task automatic stream(input bit toggle, input int ign_at);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        bit pulsed = 1'b0;
        while (i < tx_q.size() && cyc < 12000) begin
            bus.s_valid = toggle ? ph : 1'b1;
            bus.s_data  = tx_q[i];
            if (i == ign_at && !pulsed) begin
                start = 1'b1; len_words = 11'd1; pulsed = 1'b1;
            end
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            ph = ~ph;
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("stream_complete", i, tx_q.size());
        tx_q.delete();
    endtask

    task automatic wait_end(input int budget);
        int c = 0;
        while (!(done || err) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("end_timeout", (c < budget), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_write_en"}, bus.write_en, 0);
        check({tag, "_write_addr"}, bus.write_addr, 0);
        check({tag, "_write_data"}, bus.write_data, 0);
        check({tag, "_core_rst"}, core_rst, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // two-word load, continuous stream
        start_load(2);
        push_word(32'h00500013); push_word(32'h00A00093); push_trailer();
        stream(1'b0, -1);
        wait_end(20);
        check("t1_count", log_addr.size(), 2);
        check("t1_addr0", log_addr[0], 0);
        check("t1_data0", log_data[0], 32'h00500013);
        check("t1_addr1", log_addr[1], 1);
        check("t1_data1", log_data[1], 32'h00A00093);
        check("t1_done", done, 1);
        check("t1_core_rst", core_rst, 0);
        log_addr.delete(); log_data.delete();

        // same image with s_valid toggling
        start_load(2);
        push_word(32'h00500013); push_word(32'h00A00093); push_trailer();
        stream(1'b1, -1);
        wait_end(20);
        check("t2_count", log_addr.size(), 2);
        check("t2_data0", log_data[0], 32'h00500013);
        check("t2_data1", log_data[1], 32'h00A00093);
        repeat (4) @(posedge clk);
        #1;
        check("t2_done_held", done, 1);
        check("t2_core_rst_held", core_rst, 0);
        log_addr.delete(); log_data.delete();

        // illegal lengths
        bad_start(0);
        bad_start(1025);

        // reset after six bytes
        start_load(2);
        push_raw(32'h00500013); tx_q.push_back(8'h93); tx_q.push_back(8'h00);
        tx_sum = 32'd0;
        stream(1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_count", log_addr.size(), 1);
        check("t4_addr0", log_addr[0], 0);
        check("t4_data0", log_data[0], 32'h00500013);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_write_in_reset", log_addr.size(), 1);
        rst_n = 1'b1;
        log_addr.delete(); log_data.delete();
        start_load(1);
        push_word(32'h12345678); push_trailer();
        stream(1'b0, -1);
        wait_end(20);
        check("t4_reload_count", log_addr.size(), 1);
        check("t4_reload_addr", log_addr[0], 0);
        check("t4_reload_data", log_data[0], 32'h12345678);
        check("t4_reload_done", done, 1);
        log_addr.delete(); log_data.delete();

        // stray start mid-RECV
        start_load(3);
        push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333); push_trailer();
        stream(1'b0, 5);
        wait_end(20);
        check("t5_count", log_addr.size(), 3);
        check("t5_last_addr", bus.write_addr, 2);
        check("t5_done", done, 1);
        log_addr.delete(); log_data.delete();

        // full capacity: last address must be 1023 with no wrap
        start_load(1024);
        for (int w = 0; w < 1024; w++) push_word(gen(w));
        push_trailer();
        stream(1'b0, -1);
        wait_end(20);
        check("t6_count", log_addr.size(), 1024);
        check("t6_last_addr", bus.write_addr, 1023);
        check("t6_first_data", log_data[0], 32'hA5C30F11);
        check("t6_done", done, 1);
        log_addr.delete(); log_data.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
        start_load(1);
        push_raw(32'h00000013); push_raw(32'h00000013);
        stream(1'b0, -1);
        wait_end(20);
        check("t7_good_done", done, 1);
        check("t7_good_err", err, 0);
        start_load(1);
        push_raw(32'h00000013); push_raw(32'h00000014);
        stream(1'b0, -1);
        wait_end(20);
        check("t7_bad_err", err, 1);
        check("t7_bad_done", done, 0);
        check("t7_bad_core_rst", core_rst, 1);
        check("t7_bad_busy", busy, 0);
        log_addr.delete(); log_data.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
